// File: rtl/ext_mem_pkg.sv
//==============================================================================
// Module      : ext_mem_pkg
// Description : Shared types and helpers for the external-memory responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } resp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Width of the wait-state counter: enough to hold max(latency).
    function automatic int lat_w(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ext_mem_sram.sv
//==============================================================================
// Module      : ext_mem_sram
// Description : Single-port synchronous RAM with registered read data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ext_mem_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read data only updates on read cycles, so it survives later writes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ext_mem_responder.sv
//==============================================================================
// Module      : ext_mem_responder
// Description : SRAM-backed responder for the level-held external-memory
//               request interface, with per-direction wait states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ext_mem_addr,
    input  logic                  ext_mem_read,
    input  logic                  ext_mem_write,
    input  logic [DATA_WIDTH-1:0] ext_mem_wdata,
    output logic [DATA_WIDTH-1:0] ext_mem_rdata,
    output logic                  ext_mem_ready,
    output logic                  busy,
    input  logic                  err_clear,
    output logic                  addr_err,
    output logic                  proto_err
);

    localparam int LAT_W = lat_w(READ_LATENCY, WRITE_LATENCY);
    localparam logic [LAT_W-1:0] c_rd_cnt = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0] c_wr_cnt = LAT_W'(WRITE_LATENCY - 1);

    resp_state_t           r_state,     w_state_nxt;
    logic [LAT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] r_addr,      w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
    op_t                   r_op,        w_op_nxt;
    logic                  r_addr_ok,   w_addr_ok_nxt;
    logic                  r_ready,     w_ready_nxt;
    logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_addr_err,  w_addr_err_nxt;
    logic                  r_proto_err, w_proto_err_nxt;

    logic                  w_req;
    logic                  w_in_range;
    logic                  w_addr_set;
    logic                  w_proto_set;
    logic                  w_sram_en;
    logic                  w_sram_we;
    logic [DEPTH_LOG2-1:0] w_sram_addr;
    logic [DATA_WIDTH-1:0] w_sram_rdata;

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_range_chk
            assign w_in_range = ~|ext_mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end else begin : g_full_range
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_req = ext_mem_read | ext_mem_write;

    ext_mem_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (w_sram_en),
        .we    (w_sram_we),
        .addr  (w_sram_addr),
        .wdata (r_wdata),
        .rdata (w_sram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= OP_READ;
            r_addr_ok   <= 1'b0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_op        <= w_op_nxt;
            r_addr_ok   <= w_addr_ok_nxt;
            r_ready     <= w_ready_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= w_busy_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_op_nxt      = r_op;
        w_addr_ok_nxt = r_addr_ok;
        w_ready_nxt   = r_ready;
        w_rdata_nxt   = r_rdata;
        w_busy_nxt    = r_busy;
        w_sram_en     = 1'b0;
        w_sram_we     = 1'b0;
        w_sram_addr   = r_addr;
        w_addr_set    = 1'b0;
        w_proto_set   = 1'b0;

        case (r_state)
            IDLE: begin
                w_sram_addr = ext_mem_addr[DEPTH_LOG2-1:0];
                if (w_req) begin
                    w_state_nxt   = ACCESS;
                    w_busy_nxt    = 1'b1;
                    w_op_nxt      = ext_mem_read ? OP_READ : OP_WRITE;
                    w_cnt_nxt     = ext_mem_read ? c_rd_cnt : c_wr_cnt;
                    w_addr_nxt    = ext_mem_addr[DEPTH_LOG2-1:0];
                    w_wdata_nxt   = ext_mem_wdata;
                    w_addr_ok_nxt = w_in_range;
                    // The SRAM read is launched at accept so its registered
                    // output is ready by the time the wait states expire.
                    w_sram_en     = ext_mem_read & w_in_range;
                    w_proto_set   = ext_mem_read & ext_mem_write;
                    w_addr_set    = ~w_in_range;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESPOND;
                    w_ready_nxt = 1'b1;
                    if (r_op == OP_READ) begin
                        w_rdata_nxt = r_addr_ok ? w_sram_rdata : '0;
                    end else begin
                        w_sram_en = r_addr_ok;
                        w_sram_we = r_addr_ok;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            RESPOND: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        w_addr_err_nxt  = err_clear ? 1'b0 : (r_addr_err  | w_addr_set);
        w_proto_err_nxt = err_clear ? 1'b0 : (r_proto_err | w_proto_set);
    end

    assign ext_mem_rdata = r_rdata;
    assign ext_mem_ready = r_ready;
    assign busy          = r_busy;
    assign addr_err      = r_addr_err;
    assign proto_err     = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_responder.sv
//==============================================================================
// Module      : tb_ext_mem_responder
// Description : Randomized self-checking bench for ext_mem_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ext_mem_responder;

    localparam int RL = 3;
    localparam int WL = 2;
    localparam int NWORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ext_mem_addr;
    logic        ext_mem_read;
    logic        ext_mem_write;
    logic [31:0] ext_mem_wdata;
    logic [31:0] ext_mem_rdata;
    logic        ext_mem_ready;
    logic        busy;
    logic        err_clear;
    logic        addr_err;
    logic        proto_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mdl_mem [int];
    logic [31:0] mdl_rdata;
    bit          mdl_rdata_known;
    bit          mdl_aerr;
    bit          mdl_perr;

    always #5 clk = ~clk;

    ext_mem_responder #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (16),
        .DEPTH_LOG2    (10),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_mem_addr  (ext_mem_addr),
        .ext_mem_read  (ext_mem_read),
        .ext_mem_write (ext_mem_write),
        .ext_mem_wdata (ext_mem_wdata),
        .ext_mem_rdata (ext_mem_rdata),
        .ext_mem_ready (ext_mem_ready),
        .busy          (busy),
        .err_clear     (err_clear),
        .addr_err      (addr_err),
        .proto_err     (proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete handshake. Inputs are applied at a negedge so the next
    // posedge is the accept edge; outputs are sampled at negedges.
    task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [31:0] wd, input int hold,
                             input bit abort, input bit clr);
        int          lat;
        int          exp_lat;
        bit          in_rng;
        bit          rd_known;
        logic [31:0] exp_rd;

        in_rng  = (addr < NWORDS);
        exp_lat = rd ? RL : WL;
        rd_known = 1'b1;
        exp_rd   = 32'h0;
        if (rd) begin
            if (!in_rng)                  exp_rd = 32'h0;
            else if (mdl_mem.exists(addr)) exp_rd = mdl_mem[addr];
            else                           rd_known = 1'b0;
            mdl_rdata       = exp_rd;
            mdl_rdata_known = rd_known;
        end else if (wr && in_rng) begin
            mdl_mem[addr] = wd;
        end
        if (clr) begin
            mdl_perr = 1'b0;
            mdl_aerr = 1'b0;
        end else begin
            mdl_perr = mdl_perr | (rd & wr);
            mdl_aerr = mdl_aerr | !in_rng;
        end

        @(negedge clk);
        ext_mem_read  = rd;
        ext_mem_write = wr;
        ext_mem_addr  = addr;
        ext_mem_wdata = wd;
        err_clear     = clr;
        @(posedge clk);
        #1;
        err_clear     = 1'b0;
        ext_mem_addr  = 16'($urandom);
        ext_mem_wdata = $urandom;
        if (abort) begin
            ext_mem_read  = 1'b0;
            ext_mem_write = 1'b0;
        end

        @(negedge clk);
        chk("busy_after_accept", {63'h0, busy}, 64'h1);
        lat = 0;
        while (ext_mem_ready !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("ready_latency", 64'(lat), 64'(exp_lat));
        chk("proto_err", {63'h0, proto_err}, {63'h0, mdl_perr});
        chk("addr_err", {63'h0, addr_err}, {63'h0, mdl_aerr});
        if (mdl_rdata_known)
            chk("rdata_at_ready", {32'h0, ext_mem_rdata}, {32'h0, mdl_rdata});

        if (abort) begin
            @(negedge clk);
            chk("abort_ready_pulse", {63'h0, ext_mem_ready}, 64'h0);
            chk("abort_busy", {63'h0, busy}, 64'h0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("ready_held", {63'h0, ext_mem_ready}, 64'h1);
                if (mdl_rdata_known)
                    chk("rdata_held", {32'h0, ext_mem_rdata}, {32'h0, mdl_rdata});
            end
            ext_mem_read  = 1'b0;
            ext_mem_write = 1'b0;
            @(negedge clk);
            chk("ready_drop", {63'h0, ext_mem_ready}, 64'h0);
            chk("busy_drop", {63'h0, busy}, 64'h0);
        end
        if (mdl_rdata_known)
            chk("rdata_idle", {32'h0, ext_mem_rdata}, {32'h0, mdl_rdata});
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        mdl_perr  = 1'b0;
        mdl_aerr  = 1'b0;
        chk("clear_proto", {63'h0, proto_err}, 64'h0);
        chk("clear_addr", {63'h0, addr_err}, 64'h0);
    endtask

    function automatic logic [15:0] pool_addr(input int i);
        return 16'(i * 65);
    endfunction

    initial begin
        logic [15:0] a;
        int          r;
        bit          rd;
        bit          wr;

        reset         = 1'b1;
        ext_mem_addr  = '0;
        ext_mem_read  = 1'b0;
        ext_mem_write = 1'b0;
        ext_mem_wdata = '0;
        err_clear     = 1'b0;
        mdl_rdata       = 32'h0;
        mdl_rdata_known = 1'b1;
        mdl_aerr = 1'b0;
        mdl_perr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {63'h0, ext_mem_ready}, 64'h0);
        chk("rst_rdata", {32'h0, ext_mem_rdata}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_addr_err", {63'h0, addr_err}, 64'h0);
        chk("rst_proto_err", {63'h0, proto_err}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            do_access(1'b0, 1'b1, pool_addr(i), $urandom, 0, 1'b0, 1'b0);

        // Basic write then read with a long hold
        do_access(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 16'h0010, 32'h0, 5, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 16'h0010, 32'h0, 0, 1'b0, 1'b0);

        // Read and write together: read wins, write ignored
        do_access(1'b1, 1'b1, 16'h0010, 32'h12345678, 1, 1'b0, 1'b0);
        clear_errs();
        do_access(1'b1, 1'b0, 16'h0010, 32'h0, 0, 1'b0, 1'b0);

        // Out-of-range write must not alias onto word 0
        do_access(1'b0, 1'b1, 16'h0400, 32'hAAAA5555, 0, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 16'h0000, 32'h0, 0, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 16'h0400, 32'h0, 1, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 16'h0400, 32'h0, 0, 1'b0, 1'b1);
        clear_errs();

        // Aborted write still commits
        do_access(1'b0, 1'b1, 16'h0020, 32'h0000CAFE, 0, 1'b1, 1'b0);
        do_access(1'b1, 1'b0, 16'h0020, 32'h0, 0, 1'b0, 1'b0);

        // Reset during the wait states of a read
        @(negedge clk);
        ext_mem_read = 1'b1;
        ext_mem_addr = 16'h0010;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", {63'h0, ext_mem_ready}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_rdata", {32'h0, ext_mem_rdata}, 64'h0);
        mdl_rdata = 32'h0;
        mdl_rdata_known = 1'b1;
        mdl_aerr = 1'b0;
        mdl_perr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ext_mem_read = 1'b0;
        @(negedge clk);
        do_access(1'b1, 1'b0, 16'h0010, 32'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            rd = (r < 55);
            wr = (r >= 45);
            if ($urandom_range(0, 9) == 0)
                a = 16'(NWORDS + $urandom_range(0, 16'hFBFF));
            else
                a = pool_addr($urandom_range(0, 15));
            do_access(rd, wr, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 9) == 0)
                clear_errs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
